// File: rtl/serial_feeder.sv
// ---------------------------------------------------------------------------
// serial_feeder
//   Parallel-to-serial front end for a bit-serial sequence detector.
//   WIDTH-bit words are accepted on a valid/ready handshake and shifted out
//   one bit per clock on ser_data. A one-word holding register lets the next
//   word wait while the current one shifts, so consecutive words leave with
//   no idle gap. Between words ser_data sits at IDLE_BIT.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   in_data    in   WIDTH  word to serialise (sampled only on accept)
//   in_valid   in   1      in_data valid
//   in_ready   out  1      holding register empty; accept = in_valid & in_ready
//   ser_data   out  1      serial bit (IDLE_BIT when ser_valid=0)
//   ser_valid  out  1      ser_data carries a payload bit
//   word_done  out  1      pulse coincident with the last bit of a word
//   busy       out  1      shifter or holding register occupied
// ---------------------------------------------------------------------------
module serial_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_valid_q, ser_valid_d;
  logic               word_done_q, word_done_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               last_bit;

  // Advance the shifter so the next bit to send sits at the output position.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    if (MSB_FIRST) begin
      return {s[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, s[WIDTH-1:1]};
    end
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] s);
    if (MSB_FIRST) begin
      return s[WIDTH-1];
    end else begin
      return s[0];
    end
  endfunction

  // Ready depends only on registered state, never on in_valid.
  assign in_ready = rst & ~hold_full_q;
  assign accept   = in_valid & in_ready;
  assign last_bit = (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d  = shift_once(sh_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d = '0;
          // A held word always wins; in_ready is low in that case so no
          // new word can arrive in the same cycle.
          if (hold_full_q) begin
            sh_d        = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            sh_d = in_data;
          end else begin
            state_d = S_IDLE;
          end
        end else if (accept) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are precomputed from next state so they leave straight from flops.
    ser_valid_d = (state_d == S_SHIFT);
    ser_data_d  = ser_valid_d ? out_bit(sh_d) : IDLE_BIT;
    word_done_d = ser_valid_d && (cnt_d == LAST);
    busy_d      = ser_valid_d | hold_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      ser_data_q  <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      ser_data_q  <= ser_data_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign busy      = busy_q;

endmodule
